// File: rtl/issue_ctrl_pkg.sv
// Shared constants for the decode/issue controller: RV32 major opcodes,
// the reset/flush instruction value and the issue FSM encoding.
package issue_ctrl_pkg;

   // RV32 major opcodes (instr[6:0])
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;

   // ADDI x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Issue FSM encoding
   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] TRAP  = 2'd3;

endpackage

// File: rtl/issue_scoreboard.sv
// Register scoreboard: one pending-write bit per architectural register.
// Bits are set when a load issues and cleared on its writeback; x0 is never
// tracked, so reads of register 0 always report not-busy.
module issue_scoreboard
   import issue_ctrl_pkg::*;
#(
   parameter int unsigned NREG = 32
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       set_i,
   input  logic [4:0] set_idx_i,
   input  logic       clr_i,
   input  logic [4:0] clr_idx_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic [4:0] rd_i,
   output logic       rs1_busy_o,
   output logic       rs2_busy_o,
   output logic       rd_busy_o,
   output logic       busy_o
);

   logic [NREG-1:0] sb_q;
   logic [NREG-1:0] sb_d;

   // Next-state: clear on writeback, then set on load issue so set wins
   always_comb begin
      sb_d = sb_q;
      for (int unsigned i = 1; i < NREG; i++) begin
         if (clr_i && (clr_idx_i == 5'(i))) sb_d[i] = 1'b0;
         if (set_i && (set_idx_i == 5'(i))) sb_d[i] = 1'b1;
      end
   end

   // Scoreboard state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sb_q <= '0;
      else       sb_q <= sb_d;
   end

   // Read ports; loop starts at 1 so register 0 reads as not busy
   always_comb begin
      rs1_busy_o = 1'b0;
      rs2_busy_o = 1'b0;
      rd_busy_o  = 1'b0;
      for (int unsigned i = 1; i < NREG; i++) begin
         if (rs1_i == 5'(i)) rs1_busy_o = sb_q[i];
         if (rs2_i == 5'(i)) rs2_busy_o = sb_q[i];
         if (rd_i  == 5'(i)) rd_busy_o  = sb_q[i];
      end
   end

   assign busy_o = |sb_q;

endmodule

// File: rtl/issue_ctrl.sv
// Decode/issue sequencing controller. Holds the IF/ID register, lets the
// external decoder classify the held instruction, and issues it to execute
// subject to scoreboard interlocks, SYSTEM/MISC_MEM serialisation and
// illegal-instruction trapping.
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     NREG      = 32,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(issue_ctrl_pkg::NOP_INSTR)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_valid_i,
   output logic            if_ready_o,
   input  logic [XLEN-1:0] if_instr_i,
   input  logic [XLEN-1:0] if_pc_i,
   output logic [XLEN-1:0] id_instr_o,
   output logic [XLEN-1:0] id_pc_o,
   input  logic [4:0]      dec_rs1_i,
   input  logic [4:0]      dec_rs2_i,
   input  logic [4:0]      dec_rd_i,
   input  logic            dec_use_rs1_i,
   input  logic            dec_use_rs2_i,
   input  logic            dec_we_rd_i,
   input  logic            dec_is_load_i,
   input  logic            dec_is_serial_i,
   input  logic            dec_illegal_i,
   output logic            ex_valid_o,
   input  logic            ex_ready_i,
   output logic            ex_illegal_o,
   input  logic            ex_idle_i,
   input  logic            wb_valid_i,
   input  logic [4:0]      wb_rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            sb_busy_o
);

   logic [1:0]      state_q, state_d;
   logic            id_valid_q, id_valid_d;
   logic [XLEN-1:0] id_instr_q, id_instr_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;

   logic rs1_busy, rs2_busy, rd_busy;
   logic hazard, serial_ok, fire, sb_set;

   issue_scoreboard #(.NREG(NREG)) u_sb (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .set_i      (sb_set),
      .set_idx_i  (dec_rd_i),
      .clr_i      (wb_valid_i),
      .clr_idx_i  (wb_rd_i),
      .rs1_i      (dec_rs1_i),
      .rs2_i      (dec_rs2_i),
      .rd_i       (dec_rd_i),
      .rs1_busy_o (rs1_busy),
      .rs2_busy_o (rs2_busy),
      .rd_busy_o  (rd_busy),
      .busy_o     (sb_busy_o)
   );

   assign hazard    = id_valid_q & ((dec_use_rs1_i & rs1_busy) |
                                    (dec_use_rs2_i & rs2_busy) |
                                    (dec_we_rd_i   & rd_busy));
   assign serial_ok = ex_idle_i & ~sb_busy_o;
   assign fire      = ex_valid_o & ex_ready_i;
   assign sb_set    = fire & dec_is_load_i & dec_we_rd_i & ~dec_illegal_i & (dec_rd_i != '0);

   // Issue decision; depends only on held state and decoder, never on ex_ready_i
   always_comb begin
      ex_valid_o = 1'b0;
      case (state_q)
         RUN:     ex_valid_o = id_valid_q & ~flush_i &
                               (dec_illegal_i | (~hazard & (~dec_is_serial_i | serial_ok)));
         DRAIN:   ex_valid_o = id_valid_q & serial_ok & ~flush_i;
         default: ex_valid_o = 1'b0;
      endcase
   end

   assign ex_illegal_o = ex_valid_o & dec_illegal_i;
   assign stall_o      = id_valid_q & ~fire;
   // Reset gates the fetch handshake so it drops as soon as rst_i rises
   assign if_ready_o   = ~rst_i & (state_q == RUN) & ~flush_i & (~id_valid_q | fire);

   // FSM next-state: flush returns to RUN from any state
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (fire && dec_illegal_i)        state_d = TRAP;
               else if (fire && dec_is_serial_i) state_d = WAIT;
               else if (id_valid_q && dec_is_serial_i && !serial_ok && !dec_illegal_i)
                                                 state_d = DRAIN;
            end
            DRAIN:   if (fire)      state_d = WAIT;
            WAIT:    if (ex_idle_i) state_d = RUN;
            default: state_d = state_q;
         endcase
      end
   end

   // IF/ID register next-state: flush kills, fetch loads, issue empties
   always_comb begin
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      if (flush_i) begin
         id_valid_d = 1'b0;
         id_instr_d = NOP_INSTR;
      end else if (if_valid_i && if_ready_o) begin
         id_valid_d = 1'b1;
         id_instr_d = if_instr_i;
         id_pc_d    = if_pc_i;
      end else if (fire) begin
         id_valid_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= RUN;
         id_valid_q <= 1'b0;
         id_instr_q <= NOP_INSTR;
         id_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
      end
   end

   assign id_instr_o = id_instr_q;
   assign id_pc_o    = id_pc_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: a small RV32 decoder model feeds the
// dec_* inputs from id_instr_o, a vector table covers single-instruction
// issue decisions, and hand-written sequences cover the multi-cycle cases.
// Every expected issue is queued when stimulus is driven and popped when
// the DUT fires.
module tb_issue_ctrl;
   import issue_ctrl_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        if_valid_i = 1'b0;
   logic        if_ready_o;
   logic [31:0] if_instr_i = '0;
   logic [31:0] if_pc_i = '0;
   logic [31:0] id_instr_o, id_pc_o;
   logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
   logic        dec_use_rs1_i, dec_use_rs2_i, dec_we_rd_i;
   logic        dec_is_load_i, dec_is_serial_i, dec_illegal_i;
   logic        ex_valid_o, ex_illegal_o;
   logic        ex_ready_i = 1'b0;
   logic        ex_idle_i = 1'b1;
   logic        wb_valid_i = 1'b0;
   logic [4:0]  wb_rd_i = '0;
   logic        flush_i = 1'b0;
   logic        stall_o, sb_busy_o;

   localparam logic [31:0] I_ADDI1 = 32'h0010_0093; // addi x1,x0,1
   localparam logic [31:0] I_ADDI2 = 32'h0020_0113; // addi x2,x0,2
   localparam logic [31:0] I_ADDI8 = 32'h0000_0413; // addi x8,x0,0
   localparam logic [31:0] I_LW5   = 32'h0000_2283; // lw x5,0(x0)
   localparam logic [31:0] I_LW7   = 32'h0000_2383; // lw x7,0(x0)
   localparam logic [31:0] I_LW3   = 32'h0000_2183; // lw x3,0(x0)
   localparam logic [31:0] I_ADD   = 32'h0052_8333; // add x6,x5,x5
   localparam logic [31:0] I_CSR   = 32'h3001_10F3; // csrrw x1,mstatus,x2
   localparam logic [31:0] I_FENCE = 32'h0000_000F;
   localparam logic [31:0] I_ZERO  = 32'h0000_0000;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        ill;
   } iss_t;
   iss_t expq[$];
   iss_t got;

   typedef struct {
      logic [31:0] instr;
      logic        idle;
      logic        ready;
      logic        flush;
      logic        exp_valid;
      logic        exp_ill;
      logic        exp_ifrdy;
      logic        exp_stall;
      logic        exp_busy;
   } vec_t;
   vec_t vecs[11];

   always #5 clk_i = ~clk_i;

   issue_ctrl #(.XLEN(32), .NREG(32), .NOP_INSTR(32'h0000_0013)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
      .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
      .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
      .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
      .dec_use_rs1_i(dec_use_rs1_i), .dec_use_rs2_i(dec_use_rs2_i),
      .dec_we_rd_i(dec_we_rd_i), .dec_is_load_i(dec_is_load_i),
      .dec_is_serial_i(dec_is_serial_i), .dec_illegal_i(dec_illegal_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .ex_illegal_o(ex_illegal_o), .ex_idle_i(ex_idle_i),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
      .flush_i(flush_i), .stall_o(stall_o), .sb_busy_o(sb_busy_o)
   );

   // Decoder model driven from the held instruction
   always_comb begin
      dec_rs1_i       = id_instr_o[19:15];
      dec_rs2_i       = id_instr_o[24:20];
      dec_rd_i        = id_instr_o[11:7];
      dec_use_rs1_i   = 1'b0;
      dec_use_rs2_i   = 1'b0;
      dec_we_rd_i     = 1'b0;
      dec_is_load_i   = 1'b0;
      dec_is_serial_i = 1'b0;
      dec_illegal_i   = 1'b0;
      case (id_instr_o[6:0])
         LUI, AUIPC, JAL: dec_we_rd_i = 1'b1;
         JALR:     begin dec_use_rs1_i = 1'b1; dec_we_rd_i = 1'b1; end
         BRANCH,
         STORE:    begin dec_use_rs1_i = 1'b1; dec_use_rs2_i = 1'b1; end
         LOAD:     begin dec_use_rs1_i = 1'b1; dec_we_rd_i = 1'b1; dec_is_load_i = 1'b1; end
         OP_IMM:   begin dec_use_rs1_i = 1'b1; dec_we_rd_i = 1'b1; end
         OP:       begin dec_use_rs1_i = 1'b1; dec_use_rs2_i = 1'b1; dec_we_rd_i = 1'b1; end
         MISC_MEM: dec_is_serial_i = 1'b1;
         SYSTEM:   begin dec_use_rs1_i = 1'b1; dec_we_rd_i = 1'b1; dec_is_serial_i = 1'b1; end
         default:  dec_illegal_i = 1'b1;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic ill);
      expq.push_back('{instr: instr, pc: pc, ill: ill});
   endtask

   task automatic do_reset();
      if_valid_i = 1'b0;
      flush_i    = 1'b0;
      wb_valid_i = 1'b0;
      wb_rd_i    = '0;
      rst_i      = 1'b1;
      @(negedge clk_i);
      tick();
      rst_i = 1'b0;
   endtask

   // Issue monitor: every fire must match the oldest expected issue
   always @(negedge clk_i) begin
      if (!rst_i && ex_valid_o && ex_ready_i) begin
         if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_issue: got instr %h, required no issue (t=%0t)", id_instr_o, $time);
         end else begin
            got = expq.pop_front();
            chk("issue_instr", id_instr_o, got.instr);
            chk("issue_pc", id_pc_o, got.pc);
            chk("issue_illegal", 32'(ex_illegal_o), 32'(got.ill));
         end
      end
   end

   initial begin
      logic [31:0] pc;

      //                instr    idle  rdy   fl    valid ill   ifrdy stall busy
      vecs[0]  = '{I_ADDI1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{I_ADDI1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{I_LW5,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{I_CSR,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{I_CSR,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{I_ZERO,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{I_FENCE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{I_ZERO,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{I_ADDI1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{I_LW5,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{I_ADD,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

      // Reset state
      @(negedge clk_i);
      chk("rst_id_instr", id_instr_o, 32'h0000_0013);
      chk("rst_id_pc", id_pc_o, 32'h0);
      chk("rst_ex_valid", 32'(ex_valid_o), 32'h0);
      chk("rst_if_ready", 32'(if_ready_o), 32'h0);
      chk("rst_stall", 32'(stall_o), 32'h0);
      chk("rst_sb_busy", 32'(sb_busy_o), 32'h0);
      tick();
      rst_i = 1'b0;

      // Vector table: one instruction loaded into an empty ID stage
      for (int k = 0; k < 11; k++) begin
         do_reset();
         pc         = 32'h1000 + 32'(k * 4);
         ex_ready_i = 1'b0;
         ex_idle_i  = 1'b1;
         if_valid_i = 1'b1;
         if_instr_i = vecs[k].instr;
         if_pc_i    = pc;
         @(negedge clk_i);
         chk("vec_accept", 32'(if_ready_o), 32'h1);
         tick();
         if_valid_i = 1'b0;
         ex_ready_i = vecs[k].ready;
         ex_idle_i  = vecs[k].idle;
         flush_i    = vecs[k].flush;
         if (vecs[k].exp_valid && vecs[k].ready) push(vecs[k].instr, pc, vecs[k].exp_ill);
         @(negedge clk_i);
         chk("vec_id_instr", id_instr_o, vecs[k].instr);
         chk("vec_ex_valid", 32'(ex_valid_o), 32'(vecs[k].exp_valid));
         chk("vec_ex_illegal", 32'(ex_illegal_o), 32'(vecs[k].exp_ill));
         chk("vec_if_ready", 32'(if_ready_o), 32'(vecs[k].exp_ifrdy));
         chk("vec_stall", 32'(stall_o), 32'(vecs[k].exp_stall));
         tick();
         flush_i    = 1'b0;
         ex_ready_i = 1'b0;
         @(negedge clk_i);
         chk("vec_sb_busy", 32'(sb_busy_o), 32'(vecs[k].exp_busy));
         tick();
      end

      // Back-to-back hazard-free issue
      do_reset();
      ex_ready_i = 1'b1; ex_idle_i = 1'b1;
      if_valid_i = 1'b1; if_instr_i = I_ADDI1; if_pc_i = 32'h100;
      @(negedge clk_i);
      chk("b2b_accept1", 32'(if_ready_o), 32'h1);
      tick();
      if_instr_i = I_ADDI2; if_pc_i = 32'h104;
      push(I_ADDI1, 32'h100, 1'b0);
      @(negedge clk_i);
      chk("b2b_valid1", 32'(ex_valid_o), 32'h1);
      chk("b2b_stall1", 32'(stall_o), 32'h0);
      chk("b2b_accept2", 32'(if_ready_o), 32'h1);
      tick();
      if_valid_i = 1'b0;
      push(I_ADDI2, 32'h104, 1'b0);
      @(negedge clk_i);
      chk("b2b_valid2", 32'(ex_valid_o), 32'h1);
      chk("b2b_stall2", 32'(stall_o), 32'h0);
      tick();
      @(negedge clk_i);
      chk("b2b_empty", 32'(ex_valid_o), 32'h0);
      tick();

      // Load-use interlock
      do_reset();
      ex_ready_i = 1'b1; ex_idle_i = 1'b1;
      if_valid_i = 1'b1; if_instr_i = I_LW5; if_pc_i = 32'h200;
      @(negedge clk_i);
      tick();
      if_instr_i = I_ADD; if_pc_i = 32'h204;
      push(I_LW5, 32'h200, 1'b0);
      @(negedge clk_i);
      chk("lu_lw_issue", 32'(ex_valid_o), 32'h1);
      chk("lu_add_accept", 32'(if_ready_o), 32'h1);
      tick();
      if_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         chk("lu_stall", 32'(stall_o), 32'h1);
         chk("lu_hold", 32'(ex_valid_o), 32'h0);
         chk("lu_busy", 32'(sb_busy_o), 32'h1);
         tick();
      end
      wb_valid_i = 1'b1; wb_rd_i = 5'd5;
      @(negedge clk_i);
      chk("lu_stall_wb_cycle", 32'(stall_o), 32'h1);
      tick();
      wb_valid_i = 1'b0;
      push(I_ADD, 32'h204, 1'b0);
      @(negedge clk_i);
      chk("lu_add_issue", 32'(ex_valid_o), 32'h1);
      chk("lu_busy_clear", 32'(sb_busy_o), 32'h0);
      chk("lu_no_stall", 32'(stall_o), 32'h0);
      tick();
      @(negedge clk_i);
      chk("lu_empty", 32'(ex_valid_o), 32'h0);
      tick();

      // Same-cycle set/clear of one register, and writeback to x0
      do_reset();
      ex_ready_i = 1'b1; ex_idle_i = 1'b1;
      if_valid_i = 1'b1; if_instr_i = I_LW5; if_pc_i = 32'h280;
      @(negedge clk_i);
      tick();
      if_valid_i = 1'b0;
      wb_valid_i = 1'b1; wb_rd_i = 5'd5;
      push(I_LW5, 32'h280, 1'b0);
      @(negedge clk_i);
      chk("sw_issue", 32'(ex_valid_o), 32'h1);
      tick();
      wb_rd_i = 5'd0;
      @(negedge clk_i);
      chk("sw_set_wins", 32'(sb_busy_o), 32'h1);
      tick();
      wb_rd_i = 5'd5;
      @(negedge clk_i);
      chk("sw_rd0_ignored", 32'(sb_busy_o), 32'h1);
      tick();
      wb_valid_i = 1'b0;
      @(negedge clk_i);
      chk("sw_cleared", 32'(sb_busy_o), 32'h0);
      tick();

      // Serialised SYSTEM instruction
      do_reset();
      ex_ready_i = 1'b1; ex_idle_i = 1'b0;
      if_valid_i = 1'b1; if_instr_i = I_CSR; if_pc_i = 32'h300;
      @(negedge clk_i);
      chk("ser_accept", 32'(if_ready_o), 32'h1);
      tick();
      if_instr_i = I_ADDI2; if_pc_i = 32'h304;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk("ser_drain_hold", 32'(ex_valid_o), 32'h0);
         chk("ser_drain_if_ready", 32'(if_ready_o), 32'h0);
         tick();
      end
      ex_idle_i = 1'b1;
      push(I_CSR, 32'h300, 1'b0);
      @(negedge clk_i);
      chk("ser_issue", 32'(ex_valid_o), 32'h1);
      chk("ser_issue_if_ready", 32'(if_ready_o), 32'h0);
      tick();
      ex_idle_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         chk("ser_wait_if_ready", 32'(if_ready_o), 32'h0);
         chk("ser_wait_valid", 32'(ex_valid_o), 32'h0);
         tick();
      end
      ex_idle_i = 1'b1;
      @(negedge clk_i);
      chk("ser_wait_exit_cycle", 32'(if_ready_o), 32'h0);
      tick();
      push(I_ADDI2, 32'h304, 1'b0);
      @(negedge clk_i);
      chk("ser_run_if_ready", 32'(if_ready_o), 32'h1);
      tick();
      if_valid_i = 1'b0;
      @(negedge clk_i);
      chk("ser_next_issue", 32'(ex_valid_o), 32'h1);
      tick();

      // Illegal instruction trap
      do_reset();
      ex_ready_i = 1'b1; ex_idle_i = 1'b1;
      if_valid_i = 1'b1; if_instr_i = I_ZERO; if_pc_i = 32'h400;
      @(negedge clk_i);
      tick();
      if_valid_i = 1'b0;
      push(I_ZERO, 32'h400, 1'b1);
      @(negedge clk_i);
      chk("trap_issue", 32'(ex_valid_o), 32'h1);
      chk("trap_illegal", 32'(ex_illegal_o), 32'h1);
      tick();
      if_valid_i = 1'b1; if_instr_i = I_ADDI1; if_pc_i = 32'h404;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("trap_if_ready", 32'(if_ready_o), 32'h0);
         chk("trap_valid", 32'(ex_valid_o), 32'h0);
         tick();
      end
      flush_i = 1'b1;
      @(negedge clk_i);
      chk("trap_flush_if_ready", 32'(if_ready_o), 32'h0);
      tick();
      flush_i = 1'b0;
      push(I_ADDI1, 32'h404, 1'b0);
      @(negedge clk_i);
      chk("trap_exit_if_ready", 32'(if_ready_o), 32'h1);
      tick();
      if_valid_i = 1'b0;
      @(negedge clk_i);
      chk("trap_next_issue", 32'(ex_valid_o), 32'h1);
      tick();

      // Flush with a load outstanding
      do_reset();
      ex_ready_i = 1'b1; ex_idle_i = 1'b1;
      if_valid_i = 1'b1; if_instr_i = I_LW7; if_pc_i = 32'h500;
      @(negedge clk_i);
      tick();
      if_instr_i = I_ADDI8; if_pc_i = 32'h504;
      push(I_LW7, 32'h500, 1'b0);
      @(negedge clk_i);
      chk("fl_lw_issue", 32'(ex_valid_o), 32'h1);
      tick();
      if_valid_i = 1'b1; if_instr_i = I_ADDI1; if_pc_i = 32'h508;
      flush_i = 1'b1;
      @(negedge clk_i);
      chk("fl_valid", 32'(ex_valid_o), 32'h0);
      chk("fl_if_ready", 32'(if_ready_o), 32'h0);
      tick();
      flush_i = 1'b0; if_valid_i = 1'b0;
      @(negedge clk_i);
      chk("fl_id_nop", id_instr_o, 32'h0000_0013);
      chk("fl_id_empty", 32'(stall_o), 32'h0);
      chk("fl_no_issue", 32'(ex_valid_o), 32'h0);
      chk("fl_sb_kept", 32'(sb_busy_o), 32'h1);
      tick();
      tick();
      wb_valid_i = 1'b1; wb_rd_i = 5'd7;
      @(negedge clk_i);
      chk("fl_sb_before_wb", 32'(sb_busy_o), 32'h1);
      tick();
      wb_valid_i = 1'b0;
      @(negedge clk_i);
      chk("fl_sb_after_wb", 32'(sb_busy_o), 32'h0);
      tick();

      // Asynchronous reset while draining for a serial instruction
      do_reset();
      ex_ready_i = 1'b1; ex_idle_i = 1'b1;
      if_valid_i = 1'b1; if_instr_i = I_LW3; if_pc_i = 32'h600;
      @(negedge clk_i);
      tick();
      if_instr_i = I_CSR; if_pc_i = 32'h604;
      push(I_LW3, 32'h600, 1'b0);
      @(negedge clk_i);
      tick();
      if_instr_i = I_ADDI1; if_pc_i = 32'h608;
      @(negedge clk_i);
      chk("ar_run_hold", 32'(ex_valid_o), 32'h0);
      tick();
      @(negedge clk_i);
      chk("ar_drain_hold", 32'(ex_valid_o), 32'h0);
      chk("ar_drain_busy", 32'(sb_busy_o), 32'h1);
      chk("ar_drain_if_ready", 32'(if_ready_o), 32'h0);
      #2;
      rst_i = 1'b1;
      if_valid_i = 1'b0;
      #1;
      chk("ar_valid_drop", 32'(ex_valid_o), 32'h0);
      chk("ar_if_ready_drop", 32'(if_ready_o), 32'h0);
      chk("ar_sb_clear", 32'(sb_busy_o), 32'h0);
      chk("ar_id_nop", id_instr_o, 32'h0000_0013);
      chk("ar_id_pc", id_pc_o, 32'h0);
      chk("ar_stall", 32'(stall_o), 32'h0);
      #1;
      rst_i = 1'b0;
      tick();
      if_valid_i = 1'b1; if_instr_i = I_ADDI2; if_pc_i = 32'h700;
      push(I_ADDI2, 32'h700, 1'b0);
      @(negedge clk_i);
      chk("ar_run_if_ready", 32'(if_ready_o), 32'h1);
      tick();
      if_valid_i = 1'b0;
      @(negedge clk_i);
      chk("ar_run_issue", 32'(ex_valid_o), 32'h1);
      tick();

      chk("queue_drained", 32'(expq.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
